// File: rtl/reg_file_param_pkg.sv
// Shared types and defaults for the parametrised register file.
// The clear sequencer's state encoding lives here so the top and sub-module agree.
package reg_file_param_pkg;

  typedef enum logic {
    RfIdle     = 1'b0,
    RfClearing = 1'b1
  } rf_state_e;

  localparam int unsigned RfDefWidth = 4;
  localparam int unsigned RfDefNregs = 4;

  // Select width; never below one bit even for tiny register counts.
  function automatic int unsigned rf_addr_width(input int unsigned nregs);
    return ($clog2(nregs) < 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-all sequencer: walks a counter over every register index, one per cycle,
// and holds BUSY for exactly NREGS cycles.
module reg_file_clr_seq
  import reg_file_param_pkg::*;
#(
  parameter int unsigned NREGS = RfDefNregs,
  parameter int unsigned AW    = rf_addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CLR,
  output logic          BUSY,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // Terminate on the last index rather than on wrap so odd register counts work.
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  rf_state_e     r_state, w_state_d;
  logic [AW-1:0] r_cnt, w_cnt_d;
  logic          r_busy, w_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RfIdle;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_busy_d  = r_busy;
    clr_we    = 1'b0;
    clr_addr  = r_cnt;
    unique case (r_state)
      RfIdle: begin
        if (CLR) begin
          w_state_d = RfClearing;
          w_cnt_d   = '0;
          w_busy_d  = 1'b1;
        end
      end
      RfClearing: begin
        clr_we = 1'b1;
        if (r_cnt == LastIdx) begin
          w_state_d = RfIdle;
          w_cnt_d   = '0;
          w_busy_d  = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = RfIdle;
    endcase
  end

  assign BUSY = r_busy;

endmodule

// File: rtl/reg_file_param.sv
// NREGS x WIDTH register file: two combinational read ports, one write port,
// optional hardwired-zero R0, optional write-to-read bypass and a clear-all sequence.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int unsigned WIDTH    = RfDefWidth,
  parameter int unsigned NREGS    = RfDefNregs,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b0,
  localparam int unsigned AW      = rf_addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    SEL_A,
  input  logic [AW-1:0]    SEL_B,
  input  logic [AW-1:0]    SEL_W,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             CLR,
  output logic [WIDTH-1:0] OUT_A,
  output logic [WIDTH-1:0] OUT_B,
  output logic             BUSY
);

  logic [WIDTH-1:0] w_mem [NREGS];
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_port_we;

  reg_file_clr_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .CLR      (CLR),
    .BUSY     (BUSY),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // A clear request in the same cycle wins over the port write.
  always_comb begin
    w_port_we = WE && !BUSY && !CLR && (32'(SEL_W) < NREGS) &&
                !(ZERO_REG && (SEL_W == '0));
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_clr_we && (w_clr_addr == AW'(gi))) begin
        r_q <= '0;
      end else if (w_port_we && (SEL_W == AW'(gi))) begin
        r_q <= DATA_IN;
      end
    end

    assign w_mem[gi] = r_q;
  end

  always_comb begin
    OUT_A = '0;
    OUT_B = '0;
    if ((32'(SEL_A) < NREGS) && !(ZERO_REG && (SEL_A == '0))) OUT_A = w_mem[SEL_A];
    if ((32'(SEL_B) < NREGS) && !(ZERO_REG && (SEL_B == '0))) OUT_B = w_mem[SEL_B];
    // Bypass only forwards writes that will actually land this edge.
    if (BYPASS && w_port_we && (SEL_A == SEL_W)) OUT_A = DATA_IN;
    if (BYPASS && w_port_we && (SEL_B == SEL_W)) OUT_B = DATA_IN;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: four configurations share one stimulus bus; expectations go
// through a scoreboard queue and are compared when the outputs are sampled.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel_a, sel_b, sel_w;
  logic       we, clr;
  logic [7:0] din;

  logic [3:0] a0, b0, a1, b1, a2, b2;
  logic [7:0] a3, b3;
  logic       busy0, busy1, busy2, busy3;

  always #5 clk = ~clk;

  reg_file_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w), .WE(we),
    .DATA_IN(din[3:0]), .CLR(clr), .OUT_A(a0), .OUT_B(b0), .BUSY(busy0)
  );

  reg_file_param #(.BYPASS(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w), .WE(we),
    .DATA_IN(din[3:0]), .CLR(clr), .OUT_A(a1), .OUT_B(b1), .BUSY(busy1)
  );

  reg_file_param #(.ZERO_REG(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w), .WE(we),
    .DATA_IN(din[3:0]), .CLR(clr), .OUT_A(a2), .OUT_B(b2), .BUSY(busy2)
  );

  reg_file_param #(.WIDTH(8), .NREGS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .SEL_A(sel_a), .SEL_B(sel_b), .SEL_W(sel_w), .WE(we),
    .DATA_IN(din), .CLR(clr), .OUT_A(a3), .OUT_B(b3), .BUSY(busy3)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic       we;
    logic [1:0] w;
    logic [3:0] d;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] ea;
    logic [3:0] eb;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string name, input logic [7:0] exp);
    sb_t s;
    s.name = name;
    s.exp  = exp;
    sb_q.push_back(s);
  endtask

  task automatic pop_check(input logic [7:0] act);
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow: got %0h with no expectation queued", act);
    end else begin
      s = sb_q.pop_front();
      if (act !== s.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic idle_inputs();
    we    = 1'b0;
    clr   = 1'b0;
    sel_a = 2'd0;
    sel_b = 2'd0;
    sel_w = 2'd0;
    din   = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] w, input logic [7:0] d);
    we    = 1'b1;
    sel_w = w;
    din   = d;
    @(negedge clk);
    we    = 1'b0;
  endtask

  initial begin
    int busy_cycles;

    vecs[0] = '{we: 1'b1, w: 2'd1, d: 4'h5, a: 2'd1, b: 2'd0, ea: 4'h5, eb: 4'h0};
    vecs[1] = '{we: 1'b0, w: 2'd3, d: 4'hA, a: 2'd1, b: 2'd3, ea: 4'h5, eb: 4'h0};
    vecs[2] = '{we: 1'b1, w: 2'd3, d: 4'hA, a: 2'd1, b: 2'd3, ea: 4'h5, eb: 4'hA};
    vecs[3] = '{we: 1'b1, w: 2'd0, d: 4'h3, a: 2'd0, b: 2'd3, ea: 4'h3, eb: 4'hA};
    vecs[4] = '{we: 1'b1, w: 2'd2, d: 4'hC, a: 2'd2, b: 2'd1, ea: 4'hC, eb: 4'h5};
    vecs[5] = '{we: 1'b0, w: 2'd2, d: 4'hF, a: 2'd2, b: 2'd0, ea: 4'hC, eb: 4'h3};
    vecs[6] = '{we: 1'b1, w: 2'd1, d: 4'h9, a: 2'd1, b: 2'd2, ea: 4'h9, eb: 4'hC};

    // Asynchronous reset state
    idle_inputs();
    rst_n = 1'b0;
    #3;
    push("reset_busy", 8'h0);
    push("reset_out_a", 8'h0);
    pop_check({7'b0, busy0});
    pop_check({4'b0, a0});
    do_reset();

    // Table-driven writes/reads on the default configuration
    for (int i = 0; i < 7; i++) begin
      we    = vecs[i].we;
      sel_w = vecs[i].w;
      din   = {4'h0, vecs[i].d};
      sel_a = vecs[i].a;
      sel_b = vecs[i].b;
      push($sformatf("vec%0d_a", i), {4'b0, vecs[i].ea});
      push($sformatf("vec%0d_b", i), {4'b0, vecs[i].eb});
      @(negedge clk);
      pop_check({4'b0, a0});
      pop_check({4'b0, b0});
    end
    we = 1'b0;

    // Bypass versus no bypass around the write edge
    do_reset();
    sel_w = 2'd2; sel_a = 2'd2; din = 8'h0F; we = 1'b1;
    push("bypass_pre", 8'h0F);
    push("nobypass_pre", 8'h00);
    #1;
    pop_check({4'b0, a1});
    pop_check({4'b0, a0});
    push("bypass_post", 8'h0F);
    push("nobypass_post", 8'h0F);
    @(negedge clk);
    pop_check({4'b0, a1});
    pop_check({4'b0, a0});
    // A write dropped by CLR must not be forwarded
    sel_w = 2'd3; sel_a = 2'd3; din = 8'h07; clr = 1'b1;
    push("bypass_dropped", 8'h00);
    #1;
    pop_check({4'b0, a1});
    we = 1'b0; clr = 1'b0;

    // Hardwired-zero R0
    do_reset();
    sel_a = 2'd0;
    push("zero_r0", 8'h00);
    push("nonzero_r0", 8'h06);
    write_reg(2'd0, 8'h06);
    pop_check({4'b0, a2});
    pop_check({4'b0, a0});
    sel_a = 2'd2;
    push("zero_cfg_r2", 8'h05);
    write_reg(2'd2, 8'h05);
    pop_check({4'b0, a2});

    // Clear sequence on the default configuration
    do_reset();
    for (int i = 0; i < 4; i++) write_reg(2'(i), 8'(i + 1));
    clr = 1'b1; we = 1'b1; sel_w = 2'd1; din = 8'h0F;
    sel_a = 2'd0; sel_b = 2'd1;
    push("clr_e0_busy", 8'h1);
    push("clr_e0_r0_old", 8'h1);
    push("clr_e0_r1_kept", 8'h2);
    @(negedge clk);
    pop_check({7'b0, busy0});
    pop_check({4'b0, a0});
    pop_check({4'b0, b0});
    clr = 1'b0; sel_w = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      clr   = (k == 2);
      sel_a = 2'(k - 1);
      sel_b = (k < 4) ? 2'(k) : 2'(k - 1);
      push($sformatf("clr_e%0d_busy", k), (k < 4) ? 8'h1 : 8'h0);
      push($sformatf("clr_e%0d_cleared", k), 8'h0);
      push($sformatf("clr_e%0d_next", k), (k < 4) ? 8'(k + 1) : 8'h0);
      @(negedge clk);
      pop_check({7'b0, busy0});
      pop_check({4'b0, a0});
      pop_check({4'b0, b0});
    end
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 4; i += 2) begin
      sel_a = 2'(i); sel_b = 2'(i + 1);
      push($sformatf("clr_done_r%0d", i), 8'h0);
      push($sformatf("clr_done_r%0d", i + 1), 8'h0);
      #1;
      pop_check({4'b0, a0});
      pop_check({4'b0, b0});
    end
    push("clr_no_restart", 8'h0);
    @(negedge clk);
    pop_check({7'b0, busy0});

    // Asynchronous reset between edges: mid-write and mid-clear
    sel_a = 2'd1;
    push("pre_rst_write", 8'h09);
    write_reg(2'd1, 8'h09);
    pop_check({4'b0, a0});
    we = 1'b1; sel_w = 2'd1; din = 8'h09;
    #2 rst_n = 1'b0;
    push("rst_mid_write_a", 8'h0);
    push("rst_mid_write_busy", 8'h0);
    #1;
    pop_check({4'b0, a0});
    pop_check({7'b0, busy0});
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    write_reg(2'd2, 8'h04);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sel_a = 2'd2;
    push("mid_clr_busy", 8'h1);
    pop_check({7'b0, busy0});
    #2 rst_n = 1'b0;
    push("rst_mid_clr_busy", 8'h0);
    push("rst_mid_clr_a", 8'h0);
    #1;
    pop_check({7'b0, busy0});
    pop_check({4'b0, a0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NREGS=3, WIDTH=8: out-of-range select and a three-cycle clear
    do_reset();
    sel_a = 2'd2; sel_b = 2'd3;
    push("n3_r2", 8'hAB);
    push("n3_sel3", 8'h00);
    write_reg(2'd2, 8'hAB);
    pop_check(a3);
    pop_check(b3);
    sel_b = 2'd3;
    push("n3_sel3_write_dropped", 8'h00);
    write_reg(2'd3, 8'h5C);
    pop_check(b3);
    clr = 1'b1;
    push("n3_clr_cycles", 8'd3);
    push("n3_cleared_r2", 8'h00);
    @(negedge clk);
    clr = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy3) busy_cycles++;
      @(negedge clk);
    end
    pop_check(8'(busy_cycles));
    pop_check(a3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
